scroll_engine: RTL and testbench
================================

SCROLL_ENGINE -- requirements
Module: scroll_engine

Interface
REQ-001 SHALL have parameter CHAR_W, default 4, bits per character.
REQ-002 SHALL have parameter NUM_CHARS, default 16, message length in characters; legal range 2..256.
REQ-003 SHALL have parameter NUM_DIGITS, default 4, displayed window width; legal range 1..NUM_CHARS.
REQ-004 SHALL have parameter TICK_DIV, default 25000000, clk cycles per auto-scroll step; legal range >=1.
REQ-005 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port: message  input  NUM_CHARS*CHAR_W  message; char i at bits [i*CHAR_W +: CHAR_W].
REQ-008 SHALL have port: load  input  1  latch message, restart scroll.
REQ-009 SHALL have port: step  input  1  debounced button level; each rising edge gives one manual step.
REQ-010 SHALL have port: auto_en  input  1  enable timed scrolling.
REQ-011 SHALL have port: pause  input  1  freeze timed scrolling while high.
REQ-012 SHALL have port: dir  input  1  0 = forward (pos+1), 1 = backward (pos-1).
REQ-013 SHALL have port: chars  output  NUM_DIGITS*CHAR_W  window; field NUM_DIGITS-1 = leftmost digit.
REQ-014 SHALL have port: pos  output  clog2(NUM_CHARS)  current start index.
REQ-015 SHALL have port: mode  output  2  00 MANUAL, 01 RUN, 10 HOLD.
REQ-016 SHALL have port: wrap  output  1  one-cycle pulse on position wrap-around.

Function
REQ-017 SHALL hold message in internal msg_reg; updated only on a load-high cycle; the message port is ignored otherwise.
REQ-018 SHALL register chars: for k in 0..NUM_DIGITS-1, field (NUM_DIGITS-1-k) at edge t+1 = msg_reg char (pos+k) mod NUM_CHARS sampled at edge t (one-cycle lag behind pos/msg_reg).
REQ-019 SHALL detect step rising edge as step=1 while the registered previous step=0; one advance per edge; held level gives no further advances.
REQ-020 SHALL run FSM: MANUAL->RUN when auto_en=1; RUN->HOLD when pause=1; HOLD->RUN when pause=0; RUN or HOLD->MANUAL when auto_en=0 (auto_en has priority over pause).
REQ-021 SHALL run a tick counter 0..TICK_DIV-1 that increments only in RUN, holds in HOLD, and clears in MANUAL; reaching TICK_DIV-1 SHALL produce a tick and return to 0.
REQ-022 SHALL advance pos on tick or step edge, in any mode; simultaneous tick and step edge SHALL produce exactly one advance.
REQ-023 SHALL wrap modulo NUM_CHARS: forward NUM_CHARS-1->0, backward 0->NUM_CHARS-1; wrap SHALL be high exactly the cycle after that pos update (aligned with new pos).
REQ-024 SHALL let load win over any advance in the same cycle: msg_reg<=message, pos<=0, tick counter<=0, no wrap pulse; the FSM state is unaffected.
REQ-025 SHALL sample dir at the advance cycle; a dir change between steps SHALL take effect on the next advance only.
REQ-026 SHALL, with TICK_DIV=1, advance on every RUN cycle.

Reset
REQ-027 SHALL, while reset=1 at a clock edge, set msg_reg=0, pos=0, chars=0, wrap=0, mode=MANUAL, tick counter=0, and previous step=0; reset has priority over load, step and tick.
REQ-028 SHALL treat reset asserted mid-scroll identically: the next cycle after deassert resumes from pos 0, with a blank window until load.

Verification (NUM_CHARS=16, NUM_DIGITS=4, CHAR_W=4, TICK_DIV=4 unless stated)
REQ-029 SHALL cover: reset, load message 0xFEDCBA9876543210 -> pos=0, then next cycle chars=0x0123.
REQ-030 SHALL cover: manual, 13 step pulses forward -> pos=13, chars=0xDEF0; 3 more -> pos=0 with one wrap pulse.
REQ-031 SHALL cover: dir=1 at pos=0, one step -> pos=15, chars=0xF012, wrap=1 for one cycle.
REQ-032 SHALL cover: auto_en=1 for 12 cycles -> exactly 3 advances; pause 10 cycles -> pos and counter frozen; resume -> next advance after the remaining count.
REQ-033 SHALL cover: step edge coincident with tick -> single advance; load coincident with tick -> pos=0, no wrap.
REQ-034 SHALL cover: NUM_CHARS=5, NUM_DIGITS=5, TICK_DIV=1 -> pos sequence 0,1,2,3,4,0 with wrap, and window rotation correct at every step.

Source files
------------

// File: rtl/scroll_engine.sv
// Scrolling message window: shows NUM_DIGITS characters of a latched message,
// starting at pos, advanced by a manual step button or a timed auto-scroll.
module scroll_engine #(
  parameter int CHAR_W     = 4,
  parameter int NUM_CHARS  = 16,
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 25000000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CHARS*CHAR_W-1:0]    message,
  input  logic                           load,
  input  logic                           step,
  input  logic                           auto_en,
  input  logic                           pause,
  input  logic                           dir,
  output logic [NUM_DIGITS*CHAR_W-1:0]   chars,
  output logic [$clog2(NUM_CHARS)-1:0]   pos,
  output logic [1:0]                     mode,
  output logic                           wrap
);

  localparam int POS_W = $clog2(NUM_CHARS);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    MANUAL = 2'b00,
    RUN    = 2'b01,
    HOLD   = 2'b10
  } state_t;

  state_t                         state_reg;
  logic [NUM_CHARS*CHAR_W-1:0]    msg_reg;
  logic [POS_W-1:0]               pos_reg;
  logic [POS_W-1:0]               pos_next;
  logic [CNT_W-1:0]               cnt_reg;
  logic                           step_prev_reg;
  logic                           wrap_reg;
  logic [NUM_DIGITS*CHAR_W-1:0]   chars_reg;
  logic [NUM_DIGITS*CHAR_W-1:0]   chars_next;
  logic [CHAR_W-1:0]              msg_chars [NUM_CHARS];

  logic tick;
  logic step_edge;
  logic advance;
  logic at_edge;

  assign tick      = (state_reg == RUN) && (cnt_reg == CNT_W'(TICK_DIV - 1));
  assign step_edge = step & ~step_prev_reg;
  assign advance   = tick | step_edge;
  // at_edge means the next advance in the current direction wraps around
  assign at_edge   = dir ? (pos_reg == '0) : (pos_reg == POS_W'(NUM_CHARS - 1));

  always_comb begin
    pos_next = pos_reg;
    if (advance) begin
      if (at_edge)
        pos_next = dir ? POS_W'(NUM_CHARS - 1) : '0;
      else
        pos_next = dir ? (pos_reg - 1'b1) : (pos_reg + 1'b1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHARS; gi++) begin : g_msg
      assign msg_chars[gi] = msg_reg[gi*CHAR_W +: CHAR_W];
    end

    // Digit k shows char (pos+k) mod NUM_CHARS; k=0 is the leftmost field
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_win
      logic [POS_W:0]   sum;
      logic [POS_W-1:0] idx;
      assign sum = {1'b0, pos_reg} + (POS_W+1)'(gi);
      assign idx = (sum >= (POS_W+1)'(NUM_CHARS))
                   ? POS_W'(sum - (POS_W+1)'(NUM_CHARS))
                   : sum[POS_W-1:0];
      assign chars_next[(NUM_DIGITS-1-gi)*CHAR_W +: CHAR_W] = msg_chars[idx];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= MANUAL;
      msg_reg       <= '0;
      pos_reg       <= '0;
      cnt_reg       <= '0;
      step_prev_reg <= 1'b0;
      wrap_reg      <= 1'b0;
      chars_reg     <= '0;
    end else begin
      step_prev_reg <= step;
      chars_reg     <= chars_next;

      case (state_reg)
        MANUAL:  if (auto_en) state_reg <= RUN;
        RUN:     if (!auto_en) state_reg <= MANUAL;
                 else if (pause) state_reg <= HOLD;
        HOLD:    if (!auto_en) state_reg <= MANUAL;
                 else if (!pause) state_reg <= RUN;
        default: state_reg <= MANUAL;
      endcase

      if (load) begin
        msg_reg  <= message;
        pos_reg  <= '0;
        cnt_reg  <= '0;
        wrap_reg <= 1'b0;
      end else begin
        pos_reg  <= pos_next;
        wrap_reg <= advance & at_edge;
        case (state_reg)
          RUN:     cnt_reg <= tick ? '0 : (cnt_reg + 1'b1);
          HOLD:    cnt_reg <= cnt_reg;
          default: cnt_reg <= '0;
        endcase
      end
    end
  end

  assign chars = chars_reg;
  assign pos   = pos_reg;
  assign mode  = state_reg;
  assign wrap  = wrap_reg;

endmodule

// File: tb/tb_scroll_engine.sv
// Directed bench for scroll_engine: a 16-char/4-digit instance with TICK_DIV=4
// and a 5-char/5-digit instance with TICK_DIV=1.
module tb_scroll_engine;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Main instance
  logic [63:0] m_message;
  logic        m_load, m_step, m_auto, m_pause, m_dir;
  logic [15:0] m_chars;
  logic [3:0]  m_pos;
  logic [1:0]  m_mode;
  logic        m_wrap;

  scroll_engine #(.CHAR_W(4), .NUM_CHARS(16), .NUM_DIGITS(4), .TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .message(m_message), .load(m_load), .step(m_step),
    .auto_en(m_auto), .pause(m_pause), .dir(m_dir),
    .chars(m_chars), .pos(m_pos), .mode(m_mode), .wrap(m_wrap)
  );

  // Small instance
  logic [19:0] b_message;
  logic        b_load, b_step, b_auto, b_pause, b_dir;
  logic [19:0] b_chars;
  logic [2:0]  b_pos;
  logic [1:0]  b_mode;
  logic        b_wrap;

  scroll_engine #(.CHAR_W(4), .NUM_CHARS(5), .NUM_DIGITS(5), .TICK_DIV(1)) dut5 (
    .clk(clk), .reset(reset), .message(b_message), .load(b_load), .step(b_step),
    .auto_en(b_auto), .pause(b_pause), .dir(b_dir),
    .chars(b_chars), .pos(b_pos), .mode(b_mode), .wrap(b_wrap)
  );

  int tests = 0;
  int fails = 0;
  int wrap_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One manual pulse; counts wrap pulses seen on both cycles
  task automatic pulse_step();
    m_step = 1'b1;
    cyc(1);
    if (m_wrap) wrap_cnt++;
    m_step = 1'b0;
    cyc(1);
    if (m_wrap) wrap_cnt++;
  endtask

  // Expected 5-digit window for message chars i -> i+1
  function automatic logic [19:0] win5(input int p);
    logic [19:0] r;
    r = '0;
    for (int k = 0; k < 5; k++)
      r[(4-k)*4 +: 4] = 4'((p + k) % 5 + 1);
    return r;
  endfunction

  initial begin
    reset = 1'b1;
    m_message = '0; m_load = 0; m_step = 0; m_auto = 0; m_pause = 0; m_dir = 0;
    b_message = '0; b_load = 0; b_step = 0; b_auto = 0; b_pause = 0; b_dir = 0;
    cyc(2);
    chk("reset_pos", m_pos, 0);
    chk("reset_chars", m_chars, 0);
    chk("reset_mode", m_mode, 0);
    chk("reset_wrap", m_wrap, 0);
    reset = 1'b0;

    // Load and first window
    m_message = 64'hFEDC_BA98_7654_3210;
    m_load = 1'b1;
    cyc(1);
    chk("load_pos", m_pos, 0);
    m_load = 1'b0;
    cyc(1);
    chk("load_chars", m_chars, 16'h0123);

    // Manual forward stepping
    wrap_cnt = 0;
    for (int i = 0; i < 13; i++) pulse_step();
    chk("step13_pos", m_pos, 13);
    chk("step13_chars", m_chars, 16'hDEF0);
    chk("step13_nowrap", wrap_cnt, 0);
    for (int i = 0; i < 3; i++) pulse_step();
    chk("step16_pos", m_pos, 0);
    chk("step16_wrap_cnt", wrap_cnt, 1);

    // Held level advances only once
    m_step = 1'b1;
    cyc(3);
    m_step = 1'b0;
    cyc(1);
    chk("held_step_pos", m_pos, 1);

    // Backward: 1 -> 0, then wrap 0 -> 15
    m_dir = 1'b1;
    pulse_step();
    chk("back_pos0", m_pos, 0);
    m_step = 1'b1;
    cyc(1);
    chk("back_wrap_pos", m_pos, 15);
    chk("back_wrap_hi", m_wrap, 1);
    m_step = 1'b0;
    cyc(1);
    chk("back_wrap_lo", m_wrap, 0);
    chk("back_chars", m_chars, 16'hF012);
    m_dir = 1'b0;

    // Auto scroll
    m_load = 1'b1;
    cyc(1);
    m_load = 1'b0;
    m_auto = 1'b1;
    cyc(1);
    chk("auto_mode_run", m_mode, 2'b01);
    chk("auto_start_pos", m_pos, 0);
    cyc(12);
    chk("auto_12cyc_pos", m_pos, 3);
    cyc(2);
    m_pause = 1'b1;
    cyc(1);
    chk("pause_mode_hold", m_mode, 2'b10);
    cyc(10);
    chk("pause_pos_frozen", m_pos, 3);
    m_pause = 1'b0;
    cyc(1);
    chk("resume_mode_run", m_mode, 2'b01);
    chk("resume_pos", m_pos, 3);
    cyc(1);
    chk("resume_advance", m_pos, 4);

    // Step edge coincident with tick
    cyc(3);
    m_step = 1'b1;
    cyc(1);
    chk("step_tick_single", m_pos, 5);
    m_step = 1'b0;

    // Load coincident with tick
    cyc(3);
    m_message = 64'h0123_4567_89AB_CDEF;
    m_load = 1'b1;
    cyc(1);
    chk("load_tick_pos", m_pos, 0);
    chk("load_tick_wrap", m_wrap, 0);
    chk("load_tick_mode", m_mode, 2'b01);
    m_load = 1'b0;
    cyc(1);
    chk("load_tick_chars", m_chars, 16'hFEDC);
    cyc(2);
    chk("load_cnt_cleared", m_pos, 0);
    cyc(1);
    chk("load_next_tick", m_pos, 1);

    m_auto = 1'b0;
    cyc(1);
    chk("auto_off_mode", m_mode, 2'b00);

    // Reset mid-scroll
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("midreset_pos", m_pos, 0);
    chk("midreset_chars", m_chars, 0);
    chk("midreset_mode", m_mode, 0);
    cyc(1);
    chk("midreset_blank", m_chars, 0);

    // Small instance, TICK_DIV=1
    b_message = 20'h54321;
    b_load = 1'b1;
    cyc(1);
    b_load = 1'b0;
    b_auto = 1'b1;
    cyc(1);
    chk("n5_run_pos0", b_pos, 0);
    chk("n5_chars0", b_chars, win5(0));
    for (int i = 1; i <= 6; i++) begin
      cyc(1);
      chk($sformatf("n5_pos_%0d", i), b_pos, i % 5);
      chk($sformatf("n5_wrap_%0d", i), b_wrap, (i % 5 == 0) ? 1 : 0);
      chk($sformatf("n5_chars_%0d", i), b_chars, win5((i - 1) % 5));
    end
    b_auto = 1'b0;
    cyc(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
